// File: rtl/ysyx_25060170_rf_pkg.sv
// Shared defaults and small helpers for the integer register file with
// its busy-bit scoreboard.
package ysyx_25060170_rf_pkg;

    localparam int RF_XLEN    = 32;
    localparam int RF_NREG    = 32;
    localparam int RF_NRD     = 2;
    localparam int RF_ZERO_R0 = 1;

    // Register address width; a two-entry file still needs one address bit.
    function automatic int rf_aw(input int nreg);
        if (nreg <= 2) begin
            return 1;
        end else begin
            return $clog2(nreg);
        end
    endfunction

    // Low bit of slot `port` inside a packed per-port bus of `width`-bit slots.
    function automatic int rf_lo(input int port, input int width);
        return port * width;
    endfunction

endpackage

// File: rtl/ysyx_25060170_scoreboard.sv
// Busy-bit scoreboard: per-register reservations set on issue, cleared on
// writeback or flush, a running population count, and bypass-aware queries.
module ysyx_25060170_scoreboard
    import ysyx_25060170_rf_pkg::*;
#(
    parameter int NREG    = RF_NREG,
    parameter int ZERO_R0 = RF_ZERO_R0,
    parameter int NQ      = RF_NRD + 1,
    parameter int AW      = rf_aw(RF_NREG),
    parameter int CW      = $clog2(RF_NREG + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wb_valid,
    input  logic [AW-1:0]    wb_addr,
    input  logic             fire,
    input  logic             fire_rd_en,
    input  logic [AW-1:0]    fire_rd,
    input  logic             flush,
    input  logic [NQ*AW-1:0] qry_addr,
    output logic [NQ-1:0]    qry_busy,
    output logic [CW-1:0]    busy_cnt
);

    localparam logic ZR = (ZERO_R0 != 32'sd0);
    localparam logic [NREG-1:0] ONE_HOT0 = {{(NREG-1){1'b0}}, 1'b1};

    logic [NREG-1:0] busy_q;
    logic [NREG-1:0] busy_d;
    logic [CW-1:0]   cnt_q;
    logic [CW-1:0]   cnt_d;
    logic            set_s;
    logic            inc_s;
    logic            dec_s;
    logic [NREG-1:0] set_mask_s;
    logic [NREG-1:0] clr_mask_s;

    // Next busy vector and count; a set on the register being written back wins.
    always_comb begin
        set_s      = fire && fire_rd_en && !(ZR && (fire_rd == {AW{1'b0}}));
        set_mask_s = set_s    ? (ONE_HOT0 << fire_rd) : {NREG{1'b0}};
        clr_mask_s = wb_valid ? (ONE_HOT0 << wb_addr) : {NREG{1'b0}};
        inc_s      = set_s && !busy_q[fire_rd];
        dec_s      = wb_valid && busy_q[wb_addr] && !(set_s && (fire_rd == wb_addr));
        busy_d     = flush ? {NREG{1'b0}} : ((busy_q & ~clr_mask_s) | set_mask_s);
        cnt_d      = flush ? {CW{1'b0}}
                           : (cnt_q + {{(CW-1){1'b0}}, inc_s} - {{(CW-1){1'b0}}, dec_s});
    end

    // Reservation state and count registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            busy_q <= {NREG{1'b0}};
            cnt_q  <= {CW{1'b0}};
        end else begin
            busy_q <= busy_d;
            cnt_q  <= cnt_d;
        end
    end

    // A register being written back this cycle is already free for consumers.
    for (genvar q = 0; q < NQ; q++) begin : g_qry
        logic [AW-1:0] a_s;
        assign a_s         = qry_addr[rf_lo(q, AW) +: AW];
        assign qry_busy[q] = busy_q[a_s]
                             && !(wb_valid && (wb_addr == a_s))
                             && !(ZR && (a_s == {AW{1'b0}}));
    end

    assign busy_cnt = cnt_q;

endmodule

// File: rtl/ysyx_25060170_regfile_sb.sv
// Integer register file with combinational bypassed read ports and an
// issue handshake that stalls on RAW/WAW hazards against the scoreboard.
module ysyx_25060170_regfile_sb
    import ysyx_25060170_rf_pkg::*;
#(
    parameter  int XLEN    = RF_XLEN,
    parameter  int NREG    = RF_NREG,
    parameter  int NRD     = RF_NRD,
    parameter  int ZERO_R0 = RF_ZERO_R0,
    localparam int AW      = rf_aw(NREG),
    localparam int CW      = $clog2(NREG + 1)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                wb_valid,
    input  logic [AW-1:0]       wb_addr,
    input  logic [XLEN-1:0]     wb_data,
    input  logic                iss_valid,
    output logic                iss_ready,
    input  logic [NRD-1:0]      iss_rs_en,
    input  logic [NRD*AW-1:0]   iss_rs_addr,
    output logic [NRD*XLEN-1:0] iss_rs_data,
    input  logic                iss_rd_en,
    input  logic [AW-1:0]       iss_rd,
    input  logic                flush,
    output logic [CW-1:0]       busy_cnt
);

    localparam logic ZR = (ZERO_R0 != 32'sd0);

    logic [XLEN-1:0]       regs_q [NREG];
    logic [XLEN-1:0]       regs_d [NREG];
    logic                  wr_en_s;
    logic [(NRD+1)*AW-1:0] qry_addr_s;
    logic [NRD:0]          qry_busy_s;
    logic                  src_ok_s;
    logic                  dst_ok_s;
    logic                  fire_s;

    // Storage update; a hardwired zero register swallows writes.
    always_comb begin
        regs_d  = regs_q;
        wr_en_s = wb_valid && !(ZR && (wb_addr == {AW{1'b0}}));
        if (wr_en_s) begin
            regs_d[wb_addr] = wb_data;
        end else begin
            regs_d[wb_addr] = regs_q[wb_addr];
        end
    end

    // Register storage flops.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NREG; i++) begin
                regs_q[i] <= {XLEN{1'b0}};
            end
        end else begin
            regs_q <= regs_d;
        end
    end

    for (genvar k = 0; k < NRD; k++) begin : g_rd
        logic [AW-1:0]   addr_s;
        logic [XLEN-1:0] data_s;
        assign addr_s = iss_rs_addr[rf_lo(k, AW) +: AW];

        // Read mux: zero register, then writeback bypass, then storage.
        always_comb begin
            data_s = {XLEN{1'b0}};
            if (!rst) begin
                data_s = {XLEN{1'b0}};
            end else if (ZR && (addr_s == {AW{1'b0}})) begin
                data_s = {XLEN{1'b0}};
            end else if (wb_valid && (wb_addr == addr_s)) begin
                data_s = wb_data;
            end else begin
                data_s = regs_q[addr_s];
            end
        end

        assign iss_rs_data[rf_lo(k, XLEN) +: XLEN] = data_s;
    end

    // Destination query rides in the slot above the source ports.
    assign qry_addr_s = {iss_rd, iss_rs_addr};

    // Hazard check: every used source and the destination must be free.
    always_comb begin
        src_ok_s = 1'b1;
        for (int k = 0; k < NRD; k++) begin
            if (iss_rs_en[k] && qry_busy_s[k]) begin
                src_ok_s = 1'b0;
            end else begin
                src_ok_s = src_ok_s;
            end
        end
        dst_ok_s  = !(iss_rd_en && qry_busy_s[NRD]);
        iss_ready = rst && !flush && src_ok_s && dst_ok_s;
    end

    assign fire_s = iss_valid && iss_ready;

    ysyx_25060170_scoreboard #(
        .NREG    (NREG),
        .ZERO_R0 (ZERO_R0),
        .NQ      (NRD + 1),
        .AW      (AW),
        .CW      (CW)
    ) u_sb (
        .clk        (clk),
        .rst        (rst),
        .wb_valid   (wb_valid),
        .wb_addr    (wb_addr),
        .fire       (fire_s),
        .fire_rd_en (iss_rd_en),
        .fire_rd    (iss_rd),
        .flush      (flush),
        .qry_addr   (qry_addr_s),
        .qry_busy   (qry_busy_s),
        .busy_cnt   (busy_cnt)
    );

endmodule

// File: tb/tb_ysyx_25060170_regfile_sb.sv
// Bench for the register file / scoreboard: default instance plus a
// 16-entry, 3-port, writable-x0 instance, directed scenarios and random traffic.
module tb_ysyx_25060170_regfile_sb;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;
    int   n_chk  = 0;
    int   n_pass = 0;

    // instance A: defaults (32 regs, 2 ports, x0 hardwired)
    logic        a_wb_valid, a_iss_valid, a_iss_ready, a_rd_en, a_flush;
    logic [4:0]  a_wb_addr, a_rd;
    logic [31:0] a_wb_data;
    logic [1:0]  a_rs_en;
    logic [9:0]  a_rs_addr;
    logic [63:0] a_rs_data;
    logic [5:0]  a_busy_cnt;

    // instance B: 16 regs, 3 ports, x0 ordinary
    logic        b_wb_valid, b_iss_valid, b_iss_ready, b_rd_en, b_flush;
    logic [3:0]  b_wb_addr, b_rd;
    logic [31:0] b_wb_data;
    logic [2:0]  b_rs_en;
    logic [11:0] b_rs_addr;
    logic [95:0] b_rs_data;
    logic [4:0]  b_busy_cnt;

    ysyx_25060170_regfile_sb dut_a (
        .clk(clk), .rst(rst), .wb_valid(a_wb_valid), .wb_addr(a_wb_addr), .wb_data(a_wb_data),
        .iss_valid(a_iss_valid), .iss_ready(a_iss_ready), .iss_rs_en(a_rs_en),
        .iss_rs_addr(a_rs_addr), .iss_rs_data(a_rs_data), .iss_rd_en(a_rd_en), .iss_rd(a_rd),
        .flush(a_flush), .busy_cnt(a_busy_cnt)
    );

    ysyx_25060170_regfile_sb #(.XLEN(32), .NREG(16), .NRD(3), .ZERO_R0(0)) dut_b (
        .clk(clk), .rst(rst), .wb_valid(b_wb_valid), .wb_addr(b_wb_addr), .wb_data(b_wb_data),
        .iss_valid(b_iss_valid), .iss_ready(b_iss_ready), .iss_rs_en(b_rs_en),
        .iss_rs_addr(b_rs_addr), .iss_rs_data(b_rs_data), .iss_rd_en(b_rd_en), .iss_rd(b_rd),
        .flush(b_flush), .busy_cnt(b_busy_cnt)
    );

    // ---------------- reference model ----------------
    logic [31:0] m_reg  [2][32];
    bit          m_busy [2][32];

    function automatic int nreg_of(input int i); return (i == 0) ? 32 : 16; endfunction
    function automatic int aw_of(input int i);   return (i == 0) ? 5 : 4;   endfunction
    function automatic int nrd_of(input int i);  return (i == 0) ? 2 : 3;   endfunction
    function automatic bit zero_of(input int i); return (i == 0);           endfunction

    function automatic logic [31:0] m_read(input int i, input int addr, input bit wbv,
                                           input int wba, input logic [31:0] wbd);
        if (!rst) return 32'h0;
        if (zero_of(i) && addr == 0) return 32'h0;
        if (wbv && wba == addr) return wbd;
        return m_reg[i][addr];
    endfunction

    // A register blocks issue if reserved and not being written back right now.
    function automatic bit m_blocked(input int i, input int addr, input bit wbv, input int wba);
        if (zero_of(i) && addr == 0) return 1'b0;
        if (wbv && wba == addr) return 1'b0;
        return m_busy[i][addr];
    endfunction

    function automatic bit m_ready(input int i, input logic [2:0] en, input logic [14:0] ad,
                                   input bit rde, input int rd, input bit wbv, input int wba,
                                   input bit fl);
        bit ok;
        ok = rst && !fl;
        for (int k = 0; k < nrd_of(i); k++) begin
            int a;
            a = int'(ad >> (k * aw_of(i))) & ((1 << aw_of(i)) - 1);
            if (en[k] && m_blocked(i, a, wbv, wba)) ok = 1'b0;
        end
        if (rde && m_blocked(i, rd, wbv, wba)) ok = 1'b0;
        return ok;
    endfunction

    function automatic int m_count(input int i);
        int c;
        c = 0;
        for (int r = 0; r < nreg_of(i); r++) c += int'(m_busy[i][r]);
        return c;
    endfunction

    task automatic model_edge(input int i, input bit wbv, input int wba, input logic [31:0] wbd,
                              input bit fire, input bit rde, input int rd, input bit fl);
        if (wbv && !(zero_of(i) && wba == 0)) m_reg[i][wba] = wbd;
        if (fl) begin
            for (int r = 0; r < 32; r++) m_busy[i][r] = 1'b0;
        end else begin
            if (wbv) m_busy[i][wba] = 1'b0;
            if (fire && rde && !(zero_of(i) && rd == 0)) m_busy[i][rd] = 1'b1;
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++)
            for (int r = 0; r < 32; r++) begin
                m_reg[i][r]  = 32'h0;
                m_busy[i][r] = 1'b0;
            end
    endtask

    function automatic bit ready_a();
        return m_ready(0, {1'b0, a_rs_en}, {5'b0, a_rs_addr}, a_rd_en, int'(a_rd),
                       a_wb_valid, int'(a_wb_addr), a_flush);
    endfunction

    function automatic bit ready_b();
        return m_ready(1, b_rs_en, {3'b0, b_rs_addr}, b_rd_en, int'(b_rd),
                       b_wb_valid, int'(b_wb_addr), b_flush);
    endfunction

    // One clock edge; the model follows using the inputs held across the edge.
    task automatic tick();
        bit fa, fb;
        fa = a_iss_valid && ready_a();
        fb = b_iss_valid && ready_b();
        @(posedge clk);
        if (!rst) begin
            model_reset();
        end else begin
            model_edge(0, a_wb_valid, int'(a_wb_addr), a_wb_data, fa, a_rd_en, int'(a_rd), a_flush);
            model_edge(1, b_wb_valid, int'(b_wb_addr), b_wb_data, fb, b_rd_en, int'(b_rd), b_flush);
        end
        #1;
    endtask

    task automatic idle();
        a_wb_valid = 1'b0; a_wb_addr = 5'd0; a_wb_data = 32'h0; a_iss_valid = 1'b0;
        a_rs_en = 2'b0; a_rs_addr = 10'd0; a_rd_en = 1'b0; a_rd = 5'd0; a_flush = 1'b0;
        b_wb_valid = 1'b0; b_wb_addr = 4'd0; b_wb_data = 32'h0; b_iss_valid = 1'b0;
        b_rs_en = 3'b0; b_rs_addr = 12'd0; b_rd_en = 1'b0; b_rd = 4'd0; b_flush = 1'b0;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst = 1'b0;
        model_reset();
        idle();
        a_wb_valid = 1'b1; a_wb_addr = 5'd5; a_wb_data = 32'hCAFE0005;
        a_rs_en = 2'b11; a_rs_addr = {5'd5, 5'd5}; a_iss_valid = 1'b1;
        b_wb_valid = 1'b1; b_wb_addr = 4'd5; b_wb_data = 32'hCAFE0B05; b_rs_addr = {4'd5, 4'd5, 4'd5};
        tick(); tick();
        n_chk++;
        if (a_iss_ready !== 1'b0) $display("FAIL reset_ready: got %b want 0", a_iss_ready);
        else n_pass++;
        n_chk++;
        if (a_rs_data !== 64'h0) $display("FAIL reset_rdata: got %h want 0", a_rs_data);
        else n_pass++;
        n_chk++;
        if (b_rs_data !== 96'h0) $display("FAIL reset_rdata_b: got %h want 0", b_rs_data);
        else n_pass++;
        rst = 1'b1;
        idle();
        a_rs_addr = {5'd0, 5'd5};
        b_rs_addr = {4'd0, 4'd0, 4'd5};
        tick();
        n_chk++;
        if (a_rs_data[31:0] !== 32'h0) $display("FAIL reset_x5: got %h want 0", a_rs_data[31:0]);
        else n_pass++;
        n_chk++;
        if (b_rs_data[31:0] !== 32'h0) $display("FAIL reset_x5_b: got %h want 0", b_rs_data[31:0]);
        else n_pass++;
        n_chk++;
        if (a_busy_cnt !== 6'd0) $display("FAIL reset_cnt: got %0d want 0", a_busy_cnt);
        else n_pass++;
        n_chk++;
        if (a_iss_ready !== 1'b1) $display("FAIL reset_release_ready: got %b want 1", a_iss_ready);
        else n_pass++;
    endtask

    task automatic test_write_bypass();
        idle();
        a_wb_valid = 1'b1; a_wb_addr = 5'd3; a_wb_data = 32'hDEADBEEF; a_rs_addr = {5'd0, 5'd3};
        #1;
        n_chk++;
        if (a_rs_data[31:0] !== 32'hDEADBEEF) $display("FAIL bypass_same: got %h want deadbeef", a_rs_data[31:0]);
        else n_pass++;
        tick();
        a_wb_valid = 1'b0;
        #1;
        n_chk++;
        if (a_rs_data[31:0] !== 32'hDEADBEEF) $display("FAIL stored_next: got %h want deadbeef", a_rs_data[31:0]);
        else n_pass++;
        a_wb_valid = 1'b1; a_wb_addr = 5'd0; a_wb_data = 32'h55; a_rs_addr = {5'd0, 5'd0};
        #1;
        n_chk++;
        if (a_rs_data !== 64'h0) $display("FAIL x0_bypass: got %h want 0", a_rs_data);
        else n_pass++;
        tick();
        idle();
        #1;
        n_chk++;
        if (a_rs_data !== 64'h0) $display("FAIL x0_stored: got %h want 0", a_rs_data);
        else n_pass++;
    endtask

    task automatic test_raw();
        idle();
        a_iss_valid = 1'b1; a_rd_en = 1'b1; a_rd = 5'd7;
        #1;
        n_chk++;
        if (a_iss_ready !== 1'b1) $display("FAIL raw_first_ready: got %b want 1", a_iss_ready);
        else n_pass++;
        tick();
        a_rd_en = 1'b0; a_rs_en = 2'b10; a_rs_addr = {5'd7, 5'd0};
        #1;
        n_chk++;
        if (a_iss_ready !== 1'b0) $display("FAIL raw_stall: got %b want 0", a_iss_ready);
        else n_pass++;
        n_chk++;
        if (a_busy_cnt !== 6'd1) $display("FAIL raw_cnt1: got %0d want 1", a_busy_cnt);
        else n_pass++;
        a_wb_valid = 1'b1; a_wb_addr = 5'd7; a_wb_data = 32'h12;
        #1;
        n_chk++;
        if (a_iss_ready !== 1'b1) $display("FAIL raw_wb_ready: got %b want 1", a_iss_ready);
        else n_pass++;
        n_chk++;
        if (a_rs_data[63:32] !== 32'h12) $display("FAIL raw_wb_data: got %h want 12", a_rs_data[63:32]);
        else n_pass++;
        tick();
        idle();
        #1;
        n_chk++;
        if (a_busy_cnt !== 6'd0) $display("FAIL raw_cnt0: got %0d want 0", a_busy_cnt);
        else n_pass++;
    endtask

    task automatic test_waw();
        idle();
        a_iss_valid = 1'b1; a_rd_en = 1'b1; a_rd = 5'd9;
        tick();
        n_chk++;
        if (a_iss_ready !== 1'b0) $display("FAIL waw_stall: got %b want 0", a_iss_ready);
        else n_pass++;
        a_wb_valid = 1'b1; a_wb_addr = 5'd9; a_wb_data = 32'h99;
        #1;
        n_chk++;
        if (a_iss_ready !== 1'b1) $display("FAIL waw_wb_ready: got %b want 1", a_iss_ready);
        else n_pass++;
        tick();
        a_wb_valid = 1'b0;
        #1;
        n_chk++;
        if (a_busy_cnt !== 6'd1) $display("FAIL set_wins_cnt: got %0d want 1", a_busy_cnt);
        else n_pass++;
        n_chk++;
        if (a_iss_ready !== 1'b0) $display("FAIL set_wins_busy: got %b want 0", a_iss_ready);
        else n_pass++;
        a_iss_valid = 1'b0; a_wb_valid = 1'b1;
        tick();
        idle();
        #1;
        n_chk++;
        if (a_busy_cnt !== 6'd0) $display("FAIL waw_clean: got %0d want 0", a_busy_cnt);
        else n_pass++;
    endtask

    task automatic test_flush();
        int regs [3] = '{1, 2, 4};
        idle();
        a_iss_valid = 1'b1; a_rd_en = 1'b1;
        foreach (regs[j]) begin
            a_rd = 5'(regs[j]);
            tick();
        end
        n_chk++;
        if (a_busy_cnt !== 6'd3) $display("FAIL flush_pre_cnt: got %0d want 3", a_busy_cnt);
        else n_pass++;
        a_flush = 1'b1; a_rd = 5'd5;
        #1;
        n_chk++;
        if (a_iss_ready !== 1'b0) $display("FAIL flush_no_fire: got %b want 0", a_iss_ready);
        else n_pass++;
        tick();
        idle();
        #1;
        n_chk++;
        if (a_busy_cnt !== 6'd0) $display("FAIL flush_cnt: got %0d want 0", a_busy_cnt);
        else n_pass++;
        a_iss_valid = 1'b1; a_rs_en = 2'b11; a_rs_addr = {5'd2, 5'd1}; a_rd_en = 1'b1; a_rd = 5'd4;
        #1;
        n_chk++;
        if (a_iss_ready !== 1'b1) $display("FAIL flush_after_ready: got %b want 1", a_iss_ready);
        else n_pass++;
        idle();
    endtask

    task automatic test_params();
        idle();
        b_wb_valid = 1'b1; b_wb_addr = 4'd0; b_wb_data = 32'hA5A5;
        tick();
        for (int r = 10; r < 13; r++) begin
            b_wb_addr = 4'(r); b_wb_data = 32'h1000 + 32'(r);
            tick();
        end
        b_wb_valid = 1'b0;
        b_rs_addr = {4'd12, 4'd11, 4'd10};
        #1;
        n_chk++;
        if (b_rs_data !== {32'h100C, 32'h100B, 32'h100A})
            $display("FAIL three_port: got %h want 0000100c0000100b0000100a", b_rs_data);
        else n_pass++;
        b_rs_addr = {4'd0, 4'd11, 4'd0};
        #1;
        n_chk++;
        if (b_rs_data !== {32'hA5A5, 32'h100B, 32'hA5A5})
            $display("FAIL x0_writable: got %h want 0000a5a50000100b0000a5a5", b_rs_data);
        else n_pass++;
        b_iss_valid = 1'b1; b_rd_en = 1'b1;
        for (int r = 0; r < 16; r++) begin
            b_rd = 4'(r);
            tick();
        end
        n_chk++;
        if (b_busy_cnt !== 5'd16) $display("FAIL cnt_full: got %0d want 16", b_busy_cnt);
        else n_pass++;
        b_rd = 4'd0;
        #1;
        n_chk++;
        if (b_iss_ready !== 1'b0) $display("FAIL x0_busy_stall: got %b want 0", b_iss_ready);
        else n_pass++;
        b_iss_valid = 1'b0; b_wb_valid = 1'b1; b_wb_addr = 4'd3; b_wb_data = 32'h33;
        tick();
        b_wb_valid = 1'b0;
        #1;
        n_chk++;
        if (b_busy_cnt !== 5'd15) $display("FAIL cnt_dec: got %0d want 15", b_busy_cnt);
        else n_pass++;
        b_flush = 1'b1;
        tick();
        idle();
        #1;
        n_chk++;
        if (b_busy_cnt !== 5'd0) $display("FAIL cnt_flush_b: got %0d want 0", b_busy_cnt);
        else n_pass++;
    endtask

    function automatic int rnd_addr(input int nreg);
        if ($urandom_range(0, 3) == 0) return int'($urandom_range(0, nreg - 1));
        return int'($urandom_range(0, 7));
    endfunction

    task automatic test_random();
        for (int c = 0; c < 600; c++) begin
            if (c == 300) begin
                rst = 1'b0;
                model_reset();
            end
            if (c == 303) rst = 1'b1;
            a_wb_valid  = 1'($urandom_range(0, 1));
            a_wb_addr   = 5'(rnd_addr(32));
            a_wb_data   = $urandom;
            a_iss_valid = 1'($urandom_range(0, 1));
            a_rs_en     = 2'($urandom_range(0, 3));
            a_rs_addr   = {5'(rnd_addr(32)), 5'(rnd_addr(32))};
            a_rd_en     = 1'($urandom_range(0, 1));
            a_rd        = 5'(rnd_addr(32));
            a_flush     = ($urandom_range(0, 19) == 0);
            b_wb_valid  = 1'($urandom_range(0, 1));
            b_wb_addr   = 4'(rnd_addr(16));
            b_wb_data   = $urandom;
            b_iss_valid = 1'($urandom_range(0, 1));
            b_rs_en     = 3'($urandom_range(0, 7));
            b_rs_addr   = {4'(rnd_addr(16)), 4'(rnd_addr(16)), 4'(rnd_addr(16))};
            b_rd_en     = 1'($urandom_range(0, 1));
            b_rd        = 4'(rnd_addr(16));
            b_flush     = ($urandom_range(0, 19) == 0);
            #2;
            n_chk++;
            if (a_iss_ready !== ready_a()) $display("FAIL rnd_ready_a c=%0d: got %b want %b", c, a_iss_ready, ready_a());
            else n_pass++;
            n_chk++;
            if (b_iss_ready !== ready_b()) $display("FAIL rnd_ready_b c=%0d: got %b want %b", c, b_iss_ready, ready_b());
            else n_pass++;
            for (int k = 0; k < 2; k++) begin
                logic [31:0] e;
                e = m_read(0, int'(a_rs_addr[k*5 +: 5]), a_wb_valid, int'(a_wb_addr), a_wb_data);
                n_chk++;
                if (a_rs_data[k*32 +: 32] !== e) $display("FAIL rnd_rdata_a c=%0d k=%0d: got %h want %h", c, k, a_rs_data[k*32 +: 32], e);
                else n_pass++;
            end
            for (int k = 0; k < 3; k++) begin
                logic [31:0] e;
                e = m_read(1, int'(b_rs_addr[k*4 +: 4]), b_wb_valid, int'(b_wb_addr), b_wb_data);
                n_chk++;
                if (b_rs_data[k*32 +: 32] !== e) $display("FAIL rnd_rdata_b c=%0d k=%0d: got %h want %h", c, k, b_rs_data[k*32 +: 32], e);
                else n_pass++;
            end
            n_chk++;
            if (int'(a_busy_cnt) != m_count(0)) $display("FAIL rnd_cnt_a c=%0d: got %0d want %0d", c, a_busy_cnt, m_count(0));
            else n_pass++;
            n_chk++;
            if (int'(b_busy_cnt) != m_count(1)) $display("FAIL rnd_cnt_b c=%0d: got %0d want %0d", c, b_busy_cnt, m_count(1));
            else n_pass++;
            tick();
        end
        idle();
    endtask

    initial begin
        test_reset();
        test_write_bypass();
        test_raw();
        test_waw();
        test_flush();
        test_params();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
